// File: rtl/otter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : otter_pkg
//  Purpose  : Shared types and constants for the register-file writeback path.
//             wb_req_t carries one writeback request (destination + data).
//             adr_hit() is the common hazard compare: a match on a nonzero
//             register address (x0 never carries a hazard).
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package otter_pkg;

    localparam int REG_ADR_W = 5;
    localparam int XLEN      = 32;

    typedef struct packed {
        logic [REG_ADR_W-1:0] adr;
        logic [XLEN-1:0]      data;
    } wb_req_t;

    function automatic logic adr_hit(input logic [REG_ADR_W-1:0] query,
                                     input logic [REG_ADR_W-1:0] pending);
        return (query != '0) && (query == pending);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rf_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : rf_wb_arbiter_if
//  Purpose  : Bundle of the writeback arbiter's request, write and hazard
//             signals.
//  Ports    : alu_valid/alu_adr/alu_data/alu_ready : ALU writeback request
//             ld_valid/ld_adr/ld_data/ld_ready     : load writeback request
//             RF_WE/w_adr/w_data                   : register-file write port
//             adr1/adr2/hz1/hz2                    : pending-write hazard query
//  Modports : slave  - the arbiter
//             master - the requesters / register-file side
//  Revision : 1.0  initial release
// ============================================================================
interface rf_wb_arbiter_if;
    import otter_pkg::*;

    logic                 alu_valid;
    logic [REG_ADR_W-1:0] alu_adr;
    logic [XLEN-1:0]      alu_data;
    logic                 alu_ready;

    logic                 ld_valid;
    logic [REG_ADR_W-1:0] ld_adr;
    logic [XLEN-1:0]      ld_data;
    logic                 ld_ready;

    logic                 RF_WE;
    logic [REG_ADR_W-1:0] w_adr;
    logic [XLEN-1:0]      w_data;

    logic [REG_ADR_W-1:0] adr1;
    logic [REG_ADR_W-1:0] adr2;
    logic                 hz1;
    logic                 hz2;

    modport slave (
        input  alu_valid, alu_adr, alu_data, ld_valid, ld_adr, ld_data, adr1, adr2,
        output alu_ready, ld_ready, RF_WE, w_adr, w_data, hz1, hz2
    );

    modport master (
        output alu_valid, alu_adr, alu_data, ld_valid, ld_adr, ld_data, adr1, adr2,
        input  alu_ready, ld_ready, RF_WE, w_adr, w_data, hz1, hz2
    );

endinterface
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : wb_fifo
//  Purpose  : Load-writeback buffer. Circular FIFO of wb_req_t with per-slot
//             occupancy and address outputs so the arbiter can compare every
//             buffered destination against hazard queries.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             push, push_data - enqueue (caller guarantees !full)
//             pop             - dequeue head (caller guarantees !empty)
//             head            - oldest entry
//             full, empty     - occupancy flags
//             entry_vld/adr   - per-slot occupancy and destination address
//  Revision : 1.0  initial release
// ============================================================================
module wb_fifo
    import otter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  wire logic                                clk,
    input  wire logic                                rst,
    input  wire logic                                push,
    input  wire wb_req_t                             push_data,
    input  wire logic                                pop,
    output wb_req_t                                  head,
    output logic                                     full,
    output logic                                     empty,
    output logic [DEPTH-1:0]                         entry_vld,
    output logic [DEPTH-1:0][REG_ADR_W-1:0]          entry_adr
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    wb_req_t            mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Storage is not reset: occupancy is defined solely by the pointers/count.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // A slot is occupied when its distance from the read pointer is below count.
    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_entry
            logic [PTR_W-1:0] offset;
            assign offset       = PTR_W'(i) - rd_ptr;
            assign entry_vld[i] = ({1'b0, offset} < count);
            assign entry_adr[i] = mem[i].adr;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rf_wb_arbiter
//  Purpose  : Register-file writeback arbiter. Merges an unbuffered ALU
//             writeback with a FIFO-buffered load writeback onto a single
//             registered write port and reports pending-write hazards.
//  Ports    : CLK  - sole clock
//             RST  - synchronous active-high reset
//             bus  - rf_wb_arbiter_if.slave (requests, write port, hazards)
//  Config   : WB_ROUND_ROBIN_EN - when defined, two-way contention alternates
//             between sources (ALU first after reset); otherwise ALU always
//             wins contention.
//  Revision : 1.0  initial release
// ============================================================================
module rf_wb_arbiter
    import otter_pkg::*;
#(
    parameter int LD_DEPTH = 2
) (
    input  wire logic       CLK,
    input  wire logic       RST,
    rf_wb_arbiter_if.slave  bus
);

    wb_req_t                             ld_req;
    wb_req_t                             fifo_head;
    logic                                fifo_full;
    logic                                fifo_empty;
    logic                                push;
    logic                                alu_grant;
    logic                                ld_grant;
    logic [LD_DEPTH-1:0]                 entry_vld;
    logic [LD_DEPTH-1:0][REG_ADR_W-1:0]  entry_adr;

    logic                                wr_en;
    logic [REG_ADR_W-1:0]                wr_adr;
    logic [XLEN-1:0]                     wr_data;
    logic                                hz1_c;
    logic                                hz2_c;

    assign ld_req       = '{adr: bus.ld_adr, data: bus.ld_data};
    // Readiness depends only on fullness, never on a same-cycle pop.
    assign bus.ld_ready = !RST && !fifo_full;
    assign push         = bus.ld_valid && bus.ld_ready;

    wb_fifo #(
        .DEPTH (LD_DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (push),
        .push_data (ld_req),
        .pop       (ld_grant),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .entry_vld (entry_vld),
        .entry_adr (entry_adr)
    );

`ifdef WB_ROUND_ROBIN_EN
    logic contention;
    logic ld_turn;      // 1: load wins the next contention

    assign contention = bus.alu_valid && !fifo_empty;
    assign alu_grant  = !RST && bus.alu_valid && !(contention && ld_turn);
    assign ld_grant   = !RST && !fifo_empty   && !(contention && !ld_turn);

    always_ff @(posedge CLK) begin
        if (RST) begin
            ld_turn <= 1'b0;
        end else if (contention) begin
            ld_turn <= !ld_turn;
        end
    end
`else
    assign alu_grant = !RST && bus.alu_valid;
    assign ld_grant  = !RST && !fifo_empty && !bus.alu_valid;
`endif

    assign bus.alu_ready = alu_grant;

    // Writes to x0 complete the handshake but never assert the write enable.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_en   <= 1'b0;
            wr_adr  <= '0;
            wr_data <= '0;
        end else if (alu_grant) begin
            wr_en   <= (bus.alu_adr != '0);
            wr_adr  <= bus.alu_adr;
            wr_data <= bus.alu_data;
        end else if (ld_grant) begin
            wr_en   <= (fifo_head.adr != '0);
            wr_adr  <= fifo_head.adr;
            wr_data <= fifo_head.data;
        end else begin
            wr_en   <= 1'b0;
        end
    end

    assign bus.RF_WE  = wr_en;
    assign bus.w_adr  = wr_adr;
    assign bus.w_data = wr_data;

    // A register is pending while it sits in the FIFO or is on the write port.
    always_comb begin
        hz1_c = wr_en && adr_hit(bus.adr1, wr_adr);
        hz2_c = wr_en && adr_hit(bus.adr2, wr_adr);
        for (int i = 0; i < LD_DEPTH; i++) begin
            if (entry_vld[i] && adr_hit(bus.adr1, entry_adr[i])) hz1_c = 1'b1;
            if (entry_vld[i] && adr_hit(bus.adr2, entry_adr[i])) hz2_c = 1'b1;
        end
    end

    assign bus.hz1 = hz1_c;
    assign bus.hz2 = hz2_c;

endmodule
`default_nettype wire

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter LD_DEPTH, default 2, meaning load-writeback FIFO entries (power of two, >=2).
REQ-002 SHALL have port CLK  in  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports alu_valid in 1, alu_adr in 5, alu_data in 32 and alu_ready out 1: the ALU writeback request, unbuffered.
REQ-005 SHALL have ports ld_valid in 1, ld_adr in 5, ld_data in 32 and ld_ready out 1: the load writeback request, buffered.
REQ-006 SHALL have ports RF_WE out 1, w_adr out 5 and w_data out 32: the registered register-file write port.
REQ-007 SHALL have ports adr1 in 5, adr2 in 5, hz1 out 1 and hz2 out 1: the pending-write hazard query.

Function
REQ-008 SHALL define a handshake as complete in any cycle where valid and ready are both high at posedge.
REQ-009 SHALL push the load request into the FIFO on handshake; ld_ready = !fifo_full, independent of a same-cycle pop.
REQ-010 SHALL make a pushed entry eligible no earlier than the next cycle (no empty-FIFO bypass); minimum load latency is 2 cycles to RF_WE.
REQ-011 SHALL arbitrate each cycle between alu_valid and the FIFO head (fifo non-empty); at most one grant per cycle.
REQ-012 SHALL, with a single contender, grant it; alu_ready = ALU grant, combinational from alu_valid, FIFO state and priority state.
REQ-013 SHALL, on a grant, register RF_WE=1, w_adr and w_data from the granted source at the next posedge; with no grant, RF_WE=0 and w_adr/w_data hold.
REQ-014 SHALL, for a granted request with adr 0, complete the handshake/pop but register RF_WE=0.
REQ-015 SHALL pop the FIFO head on a load grant; FIFO pointers SHALL wrap modulo LD_DEPTH; count 0..LD_DEPTH.
REQ-016 SHALL drive hz1 high when adr1!=0 and adr1 equals the w_adr of a high RF_WE or any valid FIFO entry adr; hz2 likewise for adr2; combinational.
REQ-017 SHALL keep FIFO order; entries to the same register SHALL reach the write port oldest first.

Reset
REQ-018 SHALL, with RST high at posedge, set FIFO empty, RF_WE=0, w_adr=0, w_data=0 and priority state to ALU-first.
REQ-019 SHALL discard FIFO contents and any in-flight grant when RST asserts mid-operation; alu_ready=0 and ld_ready=0 while RST is high.
REQ-020 SHALL drive ld_ready=1 and hz1=hz2=0 in the first cycle after reset release.

Configuration
REQ-021 SHALL honour macro WB_ROUND_ROBIN_EN: when defined, resolve a two-way contention in favour of the source not granted at the last contention, starting with ALU after reset.
REQ-022 SHALL, without WB_ROUND_ROBIN_EN, always grant ALU on contention; the load is served only on cycles with alu_valid low.

Structure
REQ-023 SHALL place a wb_req_t typedef (adr 5, data 32) and constants REG_ADR_W=5 and XLEN=32 in shared package otter_pkg.
REQ-024 SHALL implement the load buffer as sub-module wb_fifo (push/pop/full/empty plus per-entry adr visibility for hazard compare).

Verification
REQ-025 SHALL verify: ALU only, alu_adr=5, alu_data=0xDEADBEEF -> alu_ready=1 in the same cycle; next cycle RF_WE=1, w_adr=5, w_data=0xDEADBEEF.
REQ-026 SHALL verify: 3 back-to-back load pushes with alu_valid=0 and depth 2 -> ld_ready=0 on the 3rd push only while full; writes emerge in order, first at cycle +2.
REQ-027 SHALL verify: alu_valid held high with FIFO non-empty -> fixed mode, load starves until alu_valid drops; RR mode, grants alternate ALU,LD,ALU,LD.
REQ-028 SHALL verify: load push to adr 7, then query adr1=7 -> hz1=1 until the cycle after RF_WE=1 with w_adr=7; adr1=0 -> hz1=0 always.
REQ-029 SHALL verify: ALU request to adr 0 -> alu_ready=1 and RF_WE stays 0.
REQ-030 SHALL verify: RST with FIFO holding 2 entries -> next cycle ld_ready=1, RF_WE=0, hz1=hz2=0, and no stale writes afterwards.
